// File: rtl/gpu_core_if.sv
// Write-only APB-style command bus between the host and the rasterizer.
interface gpu_core_if;
  logic [31:0] pAddr_i;
  logic [31:0] pDataWrite_i;
  logic        pSel_i;
  logic        pEnable_i;
  logic        pWrite_i;
  logic        fifo_full_o;

  modport master (
    output pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i,
    input  fifo_full_o
  );

  modport slave (
    input  pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i,
    output fifo_full_o
  );
endinterface

// File: rtl/gpu_core.sv
// Command-driven filled-square rasterizer: queues bus commands and writes
// clipped pixels, one per clock, into a double-buffered external SRAM.
module gpu_core #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                                clk,
  input  logic                                n_rst,
  gpu_core_if.slave                           bus,
  output logic                                CE0_o,
  output logic                                CE1_o,
  output logic                                R_W_o,
  output logic                                OE_o,
  output logic                                LB_o,
  output logic                                UB_o,
  output logic                                ZZ_o,
  output logic                                SEM_o,
  output logic [3*CHANNEL_BITS-1:0]           rgbdataout_o,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]     adddataout_o,
  output logic                                buffer_select_o
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CB       = WIDTH_BITS + 2;
  localparam logic [PTR_BITS:0]       FULL_COUNT = (PTR_BITS+1)'(FIFO_DEPTH);
  localparam logic signed [CB-1:0]    WIDTH_S    = CB'(WIDTH);
  localparam logic signed [CB-1:0]    HEIGHT_S   = CB'(HEIGHT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;

  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                acc_q, acc_now, push_ok, pop;

  logic [1:0]                  state;
  logic [31:0]                 cmd_word;
  logic [WIDTH_BITS-1:0]       pos_x, size;
  logic [HEIGHT_BITS-1:0]      pos_y;
  logic [3*CHANNEL_BITS-1:0]   colour;
  logic signed [CB-1:0]        pos_xs, pos_ys, size_s;
  logic signed [CB-1:0]        cur_x, cur_y, x_lo, x_hi, y_hi;
  logic                        in_range;
  logic                        unused_ok;

  assign acc_now         = bus.pSel_i & bus.pWrite_i & bus.pEnable_i;
  assign bus.fifo_full_o = (count == FULL_COUNT);
  assign push_ok         = acc_now & ~acc_q & ~bus.fifo_full_o;
  assign pop             = (state == IDLE) && (count != '0);

  assign pos_xs = CB'(pos_x);
  assign pos_ys = CB'(pos_y);
  assign size_s = CB'(size);
  assign in_range = (cur_x >= 0) && (cur_x < WIDTH_S) && (cur_y >= 0) && (cur_y < HEIGHT_S);

  assign OE_o  = 1'b1;
  assign ZZ_o  = 1'b0;
  assign SEM_o = 1'b1;
  assign unused_ok = ^{bus.pAddr_i, cmd_word[27:24]};

  // A held access phase pushes once: only the rising edge of the access qualifies.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      acc_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      acc_q <= acc_now;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.pDataWrite_i;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state           <= IDLE;
      cmd_word        <= '0;
      pos_x           <= '0;
      pos_y           <= '0;
      size            <= '0;
      colour          <= '0;
      buffer_select_o <= 1'b0;
      cur_x           <= '0;
      cur_y           <= '0;
      x_lo            <= '0;
      x_hi            <= '0;
      y_hi            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cmd_word <= fifo_mem[rd_ptr];
            state    <= DECODE;
          end
        end
        DECODE: begin
          state <= IDLE;
          case (cmd_word[31:28])
            4'h1: buffer_select_o <= ~buffer_select_o;
            4'h2: begin
              pos_x <= cmd_word[WIDTH_BITS-1:0];
              pos_y <= cmd_word[WIDTH_BITS+HEIGHT_BITS-1:WIDTH_BITS];
            end
            4'h3: size <= cmd_word[WIDTH_BITS-1:0];
            4'h7: begin
              colour <= cmd_word[3*CHANNEL_BITS-1:0];
              cur_x  <= pos_xs - size_s;
              cur_y  <= pos_ys - size_s;
              x_lo   <= pos_xs - size_s;
              x_hi   <= pos_xs + size_s;
              y_hi   <= pos_ys + size_s;
              state  <= FILL;
            end
            default: state <= IDLE;
          endcase
        end
        FILL: begin
          // Off-screen pixels still take their cycle so scan timing is fixed.
          if (cur_x == x_hi) begin
            cur_x <= x_lo;
            if (cur_y == y_hi) state <= IDLE;
            else               cur_y <= cur_y + 1'b1;
          end else begin
            cur_x <= cur_x + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      R_W_o        <= 1'b1;
      CE0_o        <= 1'b1;
      CE1_o        <= 1'b0;
      LB_o         <= 1'b1;
      UB_o         <= 1'b1;
      rgbdataout_o <= '0;
      adddataout_o <= '0;
    end else if (state == FILL && in_range) begin
      R_W_o        <= 1'b0;
      CE0_o        <= 1'b0;
      CE1_o        <= 1'b1;
      LB_o         <= 1'b0;
      UB_o         <= 1'b0;
      rgbdataout_o <= colour;
      adddataout_o <= {buffer_select_o, cur_y[HEIGHT_BITS-1:0], cur_x[WIDTH_BITS-1:0]};
    end else begin
      R_W_o <= 1'b1;
      CE0_o <= 1'b1;
      CE1_o <= 1'b0;
      LB_o  <= 1'b1;
      UB_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpu_core.sv
// Scoreboard bench for gpu_core: a command model queues expected pixel
// writes as commands are pushed; a monitor pops them as the SRAM strobe fires.
module tb_gpu_core;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic        CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, ZZ_o, SEM_o;
  logic [23:0] rgbdataout_o;
  logic [19:0] adddataout_o;
  logic        buffer_select_o;

  typedef struct {
    logic [19:0] addr;
    logic [23:0] rgb;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   m_x = 0, m_y = 0, m_r = 0;
  logic m_buf = 1'b0;

  gpu_core_if bus ();

  gpu_core dut (
    .clk             (tb_clk),
    .n_rst           (n_rst),
    .bus             (bus),
    .CE0_o           (CE0_o),
    .CE1_o           (CE1_o),
    .R_W_o           (R_W_o),
    .OE_o            (OE_o),
    .LB_o            (LB_o),
    .UB_o            (UB_o),
    .ZZ_o            (ZZ_o),
    .SEM_o           (SEM_o),
    .rgbdataout_o    (rgbdataout_o),
    .adddataout_o    (adddataout_o),
    .buffer_select_o (buffer_select_o)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  // Reference behaviour of one accepted command, applied in FIFO order.
  task automatic modelCommand(input logic [31:0] word);
    pix_t p;
    case (word[31:28])
      4'h1: m_buf = ~m_buf;
      4'h2: begin m_x = int'(word[9:0]); m_y = int'(word[18:10]); end
      4'h3: m_r = int'(word[9:0]);
      4'h7: begin
        for (int yy = m_y - m_r; yy <= m_y + m_r; yy++) begin
          for (int xx = m_x - m_r; xx <= m_x + m_r; xx++) begin
            if (xx >= 0 && xx < 640 && yy >= 0 && yy < 480) begin
              p.addr = {m_buf, yy[8:0], xx[9:0]};
              p.rgb  = word[23:0];
              exp_q.push_back(p);
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [31:0] word, input bit accepted);
    @(negedge tb_clk);
    bus.pSel_i       = 1'b1;
    bus.pWrite_i     = 1'b1;
    bus.pEnable_i    = 1'b0;
    bus.pDataWrite_i = word;
    bus.pAddr_i      = 32'h0;
    @(negedge tb_clk);
    bus.pEnable_i = 1'b1;
    @(negedge tb_clk);
    bus.pEnable_i = 1'b1;
    @(negedge tb_clk);
    bus.pSel_i    = 1'b0;
    bus.pEnable_i = 1'b0;
    bus.pWrite_i  = 1'b0;
    if (accepted) modelCommand(word);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge tb_clk);
      n++;
    end
    repeat (6) @(negedge tb_clk);
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Every write strobe must match the oldest outstanding expected pixel.
  always @(negedge tb_clk) begin
    if (n_rst === 1'b0 && R_W_o === 1'b0) begin
      pix_t p;
      wr_count++;
      checkOutput("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        checkOutput("pixel_addr", 64'(adddataout_o), 64'(p.addr));
        checkOutput("pixel_rgb", 64'(rgbdataout_o), 64'(p.rgb));
        checkOutput("write_strobes", 64'({CE0_o, CE1_o, LB_o, UB_o}), 64'(4'b0100));
      end
    end
  end

  initial begin
    int start;
    int n;
    bus.pSel_i = 1'b0; bus.pEnable_i = 1'b0; bus.pWrite_i = 1'b0;
    bus.pDataWrite_i = 32'h0; bus.pAddr_i = 32'h0;
    n_rst = 1'b1;
    repeat (3) @(negedge tb_clk);

    checkOutput("rst_fifo_full", 64'(bus.fifo_full_o), 64'd0);
    checkOutput("rst_R_W", 64'(R_W_o), 64'd1);
    checkOutput("rst_CE0", 64'(CE0_o), 64'd1);
    checkOutput("rst_CE1", 64'(CE1_o), 64'd0);
    checkOutput("rst_OE", 64'(OE_o), 64'd1);
    checkOutput("rst_LB_UB", 64'({LB_o, UB_o}), 64'd3);
    checkOutput("rst_ZZ", 64'(ZZ_o), 64'd0);
    checkOutput("rst_SEM", 64'(SEM_o), 64'd1);
    checkOutput("rst_rgb", 64'(rgbdataout_o), 64'd0);
    checkOutput("rst_addr", 64'(adddataout_o), 64'd0);
    checkOutput("rst_buffer", 64'(buffer_select_o), 64'd0);
    n_rst = 1'b0;
    repeat (2) @(negedge tb_clk);

    $display("[TB] single pixel fill");
    start = wr_count;
    applyStimulus(32'h30000000, 1'b1);
    applyStimulus(32'h2003C140, 1'b1);
    applyStimulus(32'h70FF0000, 1'b1);
    waitDrain("drain_single", 200);
    checkOutput("single_count", 64'(wr_count - start), 64'd1);

    $display("[TB] 41x41 fill");
    start = wr_count;
    applyStimulus(32'h30000014, 1'b1);
    applyStimulus(32'h2003C140, 1'b1);
    applyStimulus(32'h7100FF00, 1'b1);
    waitDrain("drain_square", 3000);
    checkOutput("square_count", 64'(wr_count - start), 64'd1681);

    $display("[TB] clipped fill at corner");
    start = wr_count;
    applyStimulus(32'h30000014, 1'b1);
    applyStimulus(32'h20001405, 1'b1);
    applyStimulus(32'h70123456, 1'b1);
    waitDrain("drain_clip", 3000);
    checkOutput("clip_count", 64'(wr_count - start), 64'd676);

    $display("[TB] buffer swap");
    applyStimulus(32'h10000000, 1'b1);
    applyStimulus(32'h70ABCDEF, 1'b1);
    waitDrain("drain_swap", 3000);
    checkOutput("swap_buffer", 64'(buffer_select_o), 64'd1);
    checkOutput("swap_addr_msb", 64'(adddataout_o[19]), 64'd1);

    $display("[TB] FIFO fill during long raster");
    applyStimulus(32'h2003C140, 1'b1);
    start = wr_count;
    applyStimulus(32'h70AAAAAA, 1'b1);
    n = 0;
    while (wr_count == start && n < 100) begin
      @(negedge tb_clk);
      n++;
    end
    checkOutput("fill_started", 64'(wr_count != start), 64'd1);
    applyStimulus(32'h20019064, 1'b1);
    applyStimulus(32'h30000005, 1'b1);
    applyStimulus(32'h200320C8, 1'b1);
    applyStimulus(32'h30000001, 1'b1);
    applyStimulus(32'h10000000, 1'b1);
    applyStimulus(32'h10000000, 1'b1);
    applyStimulus(32'h20002407, 1'b1);
    checkOutput("full_after_7", 64'(bus.fifo_full_o), 64'd0);
    applyStimulus(32'h70123ABC, 1'b1);
    checkOutput("full_after_8", 64'(bus.fifo_full_o), 64'd1);
    applyStimulus(32'h70FFFFFF, 1'b0);
    checkOutput("full_after_9", 64'(bus.fifo_full_o), 64'd1);
    waitDrain("drain_fifo", 4000);
    checkOutput("empty_after_drain", 64'(bus.fifo_full_o), 64'd0);
    checkOutput("final_buffer", 64'(buffer_select_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
